// File: rtl/alu_exec_stage.sv
// alu_exec_stage: single-issue ALU execute stage with a registered result.
// Latency: 1 cycle for AND/OR/XOR/NOR/ADD/SUB/SLT. MUL is a shift-add that takes WIDTH cycles.
// Backpressure: the result is held while out_ready=0. in_ready is 1 in IDLE, 0 during MUL,
//   and follows out_ready while a result is held.
// Ports:
//   clk, rst (asynchronous, active-high)
//   in_valid/in_ready, op[2:0], x, y   - operation handshake and operands
//   out_valid/out_ready, s             - result handshake and registered result
//   busy                               - a multi-cycle MUL is in progress
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each iteration
  logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, shifted right each iteration
  logic [WIDTH-1:0] acc_q, acc_d;       // running partial product
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] partial;

  // Single-cycle operations. MUL never reaches this path.
  function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] f_op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (f_op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Partial product including this iteration's multiplier bit.
  assign partial = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;

    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_MUL:  in_ready = 1'b0;
      ST_HOLD: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase

    accept = in_valid && in_ready;

    case (state_q)
      ST_MUL: begin
        acc_d    = partial;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          s_d     = partial;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Held result is consumed on out_ready; with no new op, fall back to IDLE.
        if (out_ready && !in_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    // A new op can start from IDLE or from HOLD in the same edge the old result is consumed.
    if (accept) begin
      if (op == OP_MUL) begin
        state_d  = ST_MUL;
        mcand_d  = x;
        mplier_d = y;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        state_d = ST_HOLD;
        s_d     = alu_f(op, x, y);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s         = s_q;
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: directed vectors checked against a cycle-level
// behavioural model, plus hand-computed literal results.
module tb_alu_exec_stage;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         busy;

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result of one operation, straight from the operation definitions.
  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a | b);
      3'd4: r = a + b;
      3'd5: r = a - b;
      3'd6: r = ($signed(a) < $signed(b)) ? 1 : 0;
      default: r = a * b;
    endcase
    return r;
  endfunction

  // Behavioural model: a result is either pending (MUL countdown), held, or absent.
  logic [W-1:0] m_s    = '0;
  logic [W-1:0] m_pend = '0;
  bit           m_vld  = 0;
  bit           m_busy = 0;
  int           m_cnt  = 0;
  int           m_acc  = 0;
  int           m_drop = 0;
  bit           m_rdy;
  int           hs     = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if (m_busy || m_vld) m_drop++;
      m_s    = '0;
      m_vld  = 0;
      m_busy = 0;
      m_cnt  = 0;
    end else begin
      m_rdy = !m_busy && (!m_vld || out_ready);
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0;
          m_vld  = 1;
          m_s    = m_pend;
        end
      end else begin
        if (m_vld && out_ready) m_vld = 0;
        if (in_valid && m_rdy) begin
          m_acc++;
          if (op == 3'd7) begin
            m_busy = 1;
            m_cnt  = W;
            m_pend = ref_op(op, x, y);
          end else begin
            m_s   = ref_op(op, x, y);
            m_vld = 1;
          end
        end
      end
    end
  end

  // Every cycle, compare all outputs against the model.
  always @(negedge clk) begin
    chk("s", s, m_s);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_busy && (!m_vld || out_ready))});
    if (!rst && out_valid && out_ready) hs++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit ordy);
    in_valid  = v;
    op        = o;
    x         = a;
    y         = b;
    out_ready = ordy;
  endtask

  // Counts busy cycles until a result appears, bounded.
  task automatic wait_mul(output int bc);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      if (busy) bc++;
      step();
    end
    chk("mul_done", {31'd0, out_valid}, 32'd1);
  endtask

  int bc;
  int late_vld;

  initial begin
    rst = 1'b0;
    drive(0, 3'd0, '0, '0, 1);
    #1 rst = 1'b1;

    // Valid OR presented during reset must not be taken.
    drive(1, 3'd1, 32'hF0F0_0000, 32'h0F0F_00FF, 1);
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_s", s, 32'd0);
    rst = 1'b0;
    step();
    chk("or_vld", {31'd0, out_valid}, 32'd1);
    chk("or_s", s, 32'hFFFF_00FF);
    chk("or_model", m_s, 32'hFFFF_00FF);
    in_valid = 0;
    step();
    chk("or_idle_vld", {31'd0, out_valid}, 32'd0);
    chk("or_idle_s", s, 32'hFFFF_00FF);

    // ADD / SLT / SUB back-to-back.
    drive(1, 3'd4, 32'hFFFF_FFFF, 32'h0000_0002, 1);
    step();
    chk("add_s", s, 32'h0000_0001);
    drive(1, 3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    step();
    chk("slt_s", s, 32'h0000_0001);
    drive(1, 3'd5, 32'h0000_0000, 32'h0000_0001, 1);
    step();
    chk("sub_s", s, 32'hFFFF_FFFF);
    chk("sub_model", m_s, 32'hFFFF_FFFF);
    in_valid = 0;
    step();

    // MUL; inputs during MUL must be ignored.
    drive(1, 3'd7, 32'h0001_0003, 32'h0001_0005, 1);
    step();
    drive(1, 3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    chk("mul_inrdy", {31'd0, in_ready}, 32'd0);
    wait_mul(bc);
    chk("mul_busy_cycles", bc, 32'd32);
    chk("mul_s", s, 32'h0008_000F);
    chk("mul_model", m_pend, 32'h0008_000F);
    chk("mul_busy_end", {31'd0, busy}, 32'd0);
    in_valid = 0;
    out_ready = 1;
    step();

    // Eight single-cycle ops back-to-back, then MUL by zero immediately.
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'(i % 7), 32'h1357_9BDF * (i + 1), 32'h8642_0ACE ^ (i << 28), 1);
      step();
      chk("b2b_vld", {31'd0, out_valid}, 32'd1);
    end
    drive(1, 3'd7, 32'h0000_0000, 32'h0000_0005, 1);
    step();
    chk("mul0_vld", {31'd0, out_valid}, 32'd0);
    chk("mul0_busy", {31'd0, busy}, 32'd1);
    in_valid = 0;
    wait_mul(bc);
    chk("mul0_cycles", bc, 32'd32);
    chk("mul0_s", s, 32'd0);
    step();

    // Stall: XOR result held for 5 cycles, then consumed with an AND accepted.
    drive(1, 3'd2, 32'h1234_5678, 32'hFFFF_0000, 0);
    step();
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_s", s, 32'hEDCB_5678);
      chk("stall_vld", {31'd0, out_valid}, 32'd1);
      chk("stall_inrdy", {31'd0, in_ready}, 32'd0);
      step();
    end
    drive(1, 3'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    step();
    chk("stall_and_s", s, 32'h0F00_0F00);
    in_valid = 0;
    step();

    // Reset between edges at MUL cycle 10 aborts the multiply.
    drive(1, 3'd7, 32'h0001_0003, 32'h0001_0005, 1);
    step();
    in_valid = 0;
    for (int i = 0; i < 10; i++) step();
    #2 rst = 1'b1;
    #1;
    chk("abort_vld", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_s", s, 32'd0);
    step();
    rst = 1'b0;
    late_vld = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) late_vld++;
      step();
    end
    chk("abort_no_result", late_vld, 32'd0);

    chk("handshakes", hs, m_acc - m_drop);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
